// File: rtl/intersection_scheduler_if.sv
// intersection_scheduler_if: request, lamp, phase and grant signals of one crossing
// master drives the crossing requests; slave (the scheduler) drives lamps, phase and acks
interface intersection_scheduler_if;
  logic       ns_req, ew_req;
  logic       ns_R, ns_G, ns_Y;
  logic       ew_R, ew_G, ew_Y;
  logic [2:0] phase;
  logic       ns_ack, ew_ack;
  modport master (
    output ns_req, ew_req,
    input  ns_R, ns_G, ns_Y, ew_R, ew_G, ew_Y, phase, ns_ack, ew_ack
  );
  modport slave (
    input  ns_req, ew_req,
    output ns_R, ns_G, ns_Y, ew_R, ew_G, ew_Y, phase, ns_ack, ew_ack
  );
endinterface

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-approach signal sequencer with request-shortened greens
// clk: rising-edge clock; rst: asynchronous active-low reset
// bus (slave): ns_req/ew_req in; lamps, 3-bit phase and one-cycle ns_ack/ew_ack out
module intersection_scheduler #(
  parameter int G_MIN  = 1024,
  parameter int G_MAX  = 3072,
  parameter int BLINK  = 512,
  parameter int YELLOW = 512,
  parameter int ALLRED = 256,
  parameter int CW     = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  intersection_scheduler_if.slave bus
);
  typedef enum logic [2:0] {
    NS_GREEN, NS_BLINK, NS_YELLOW, ALLRED_A,
    EW_GREEN, EW_BLINK, EW_YELLOW, ALLRED_B
  } phase_t;
  localparam logic [CW-1:0] GMIN_L  = CW'(G_MIN - 1);
  localparam logic [CW-1:0] GMAX_L  = CW'(G_MAX - 1);
  localparam logic [CW-1:0] BLINK_L = CW'(BLINK - 1);
  localparam logic [CW-1:0] YEL_L   = CW'(YELLOW - 1);
  localparam logic [CW-1:0] AR_L    = CW'(ALLRED - 1);
  phase_t          phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d, last_l;
  logic            ns_pend_q, ns_pend_d, ew_pend_q, ew_pend_d;
  logic            ns_ack_q, ns_ack_d, ew_ack_q, ew_ack_d;
  logic            green, opp_pend, adv;
  always_comb begin
    green     = phase_q == NS_GREEN || phase_q == EW_GREEN;
    opp_pend  = phase_q == NS_GREEN ? ew_pend_q : ns_pend_q;
    last_l    = green ? GMAX_L :
                (phase_q == NS_BLINK || phase_q == EW_BLINK) ? BLINK_L :
                (phase_q == NS_YELLOW || phase_q == EW_YELLOW) ? YEL_L : AR_L;
    // a pending opposite request ends green as soon as the minimum has elapsed
    adv       = cnt_q == last_l || (green && opp_pend && cnt_q >= GMIN_L);
    phase_d   = adv ? phase_t'(phase_q + 3'd1) : phase_q;
    cnt_d     = adv ? '0 : cnt_q + CW'(1);
    // entry into own green clears pend and absorbs a request on the same edge
    ew_pend_d = (adv && phase_q == ALLRED_A) ? 1'b0 :
                ew_pend_q | (bus.ew_req && phase_q != EW_GREEN && phase_q != EW_BLINK);
    ns_pend_d = (adv && phase_q == ALLRED_B) ? 1'b0 :
                ns_pend_q | (bus.ns_req && phase_q != NS_GREEN && phase_q != NS_BLINK);
    ew_ack_d  = adv && phase_q == ALLRED_A;
    ns_ack_d  = adv && phase_q == ALLRED_B;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q   <= NS_GREEN;
      cnt_q     <= '0;
      ns_pend_q <= 1'b0;
      ew_pend_q <= 1'b0;
      ns_ack_q  <= 1'b0;
      ew_ack_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      ns_pend_q <= ns_pend_d;
      ew_pend_q <= ew_pend_d;
      ns_ack_q  <= ns_ack_d;
      ew_ack_q  <= ew_ack_d;
    end
  end
  assign bus.ns_G   = phase_q == NS_GREEN || (phase_q == NS_BLINK && cnt_q[7]);
  assign bus.ns_Y   = phase_q == NS_YELLOW;
  assign bus.ns_R   = !(phase_q inside {NS_GREEN, NS_BLINK, NS_YELLOW});
  assign bus.ew_G   = phase_q == EW_GREEN || (phase_q == EW_BLINK && cnt_q[7]);
  assign bus.ew_Y   = phase_q == EW_YELLOW;
  assign bus.ew_R   = !(phase_q inside {EW_GREEN, EW_BLINK, EW_YELLOW});
  assign bus.phase  = phase_q;
  assign bus.ns_ack = ns_ack_q;
  assign bus.ew_ack = ew_ack_q;
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: scoreboarded phase lengths plus per-cycle lamp/ack model
module tb_intersection_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  intersection_scheduler_if bus();
  intersection_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {int ph; int len;} exp_t;
  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cur_ph = 0;
  int   run = 0;
  bit   entered = 1'b0;
  logic [2:0] ens, eew;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic push(input int ph, input int len);
    exp_t x;
    x.ph = ph;
    x.len = len;
    sb.push_back(x);
  endtask
  task automatic push_period(input int g_ns, input int g_ew);
    push(0, g_ns); push(1, 512); push(2, 512); push(3, 256);
    push(4, g_ew); push(5, 512); push(6, 512); push(7, 256);
  endtask
  task automatic wait_at(input int ph, input int c);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(cur_ph == ph && run == c) && n < 20000);
    chk("wait_reached", cur_ph == ph && run == c, 1);
  endtask
  task automatic pulse_ew();
    bus.ew_req = 1'b1;
    @(negedge clk); #1;
    bus.ew_req = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_phase"}, bus.phase, 0);
    chk({tag, "_ns_lamps"}, {bus.ns_R, bus.ns_G, bus.ns_Y}, 3'b010);
    chk({tag, "_ew_lamps"}, {bus.ew_R, bus.ew_G, bus.ew_Y}, 3'b100);
    chk({tag, "_ns_ack"}, bus.ns_ack, 0);
    chk({tag, "_ew_ack"}, bus.ew_ack, 0);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      cur_ph = 0;
      run = 0;
      entered = 1'b0;
    end else begin
      if (int'(bus.phase) != cur_ph) begin
        if (sb.size() == 0) chk("unexpected_phase_change", bus.phase, cur_ph);
        else begin
          e = sb.pop_front();
          chk("phase_order", cur_ph, e.ph);
          chk("phase_len", run + 1, e.len);
        end
        chk("phase_next", bus.phase, (cur_ph + 1) % 8);
        cur_ph = int'(bus.phase);
        run = 0;
        entered = 1'b1;
      end else run++;
      ens = cur_ph == 0 ? 3'b010 : cur_ph == 1 ? {1'b0, run[7], 1'b0} :
            cur_ph == 2 ? 3'b001 : 3'b100;
      eew = cur_ph == 4 ? 3'b010 : cur_ph == 5 ? {1'b0, run[7], 1'b0} :
            cur_ph == 6 ? 3'b001 : 3'b100;
      chk("ns_lamps", {bus.ns_R, bus.ns_G, bus.ns_Y}, ens);
      chk("ew_lamps", {bus.ew_R, bus.ew_G, bus.ew_Y}, eew);
      chk("ns_ack", bus.ns_ack, entered && cur_ph == 0 && run == 0);
      chk("ew_ack", bus.ew_ack, entered && cur_ph == 4 && run == 0);
    end
  end
  initial begin
    bus.ns_req = 1'b0;
    bus.ew_req = 1'b0;
    #1;
    chk_reset("reset");
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    push_period(3072, 3072);
    wait_at(7, 0);
    push_period(1024, 3072);
    wait_at(0, 100);
    pulse_ew();
    wait_at(7, 0);
    push_period(2002, 3072);
    wait_at(0, 2000);
    pulse_ew();
    wait_at(7, 100);
    bus.ns_req = 1'b1;
    push_period(3072, 1024);
    wait_at(2, 10);
    bus.ns_req = 1'b0;
    wait_at(7, 0);
    push_period(3072, 3072);
    wait_at(3, 255);
    pulse_ew();
    push(0, 3072); push(1, 512); push(2, 512); push(3, 256); push(4, 3072); push(5, 512);
    wait_at(1, 0);
    wait_at(6, 290);
    pulse_ew();
    wait_at(6, 300);
    chk("sb_drained_before_reset", sb.size(), 0);
    rst = 1'b0;
    #1;
    chk_reset("midphase_reset");
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    push(0, 3072);
    wait_at(1, 0);
    chk("sb_drained_final", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
